// File: rtl/mmio_vga_fill_arbiter.sv
// Shares the MMIO address/write-data port between the CPU and a VGA text-buffer fill engine.
// Define VGA_FILL_COLOR_EN to also fill the colour plane after the character plane.
module mmio_vga_fill_arbiter #(
  parameter int          CELLS      = 3072,
  parameter logic [31:0] CHAR_BASE  = 32'hFFFF_E000,
  parameter logic [31:0] COLOR_BASE = 32'hFFFF_D000,
  parameter logic [31:0] CTRL_ADDR  = 32'hFFFF_FF34,
  parameter logic [31:0] STAT_ADDR  = 32'hFFFF_FF38
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CpuAccess,
  input  logic [31:0] CpuAddress,
  input  logic [31:0] CpuWriteData,
  input  logic        CpuWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic [31:0] StatusData,
  output logic        Busy,
  output logic        Done
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] FILL_CHAR  = 2'd1;
`ifdef VGA_FILL_COLOR_EN
  localparam logic [1:0] FILL_COLOR = 2'd2;
`endif
  localparam logic [1:0] FINISH     = 2'd3;

  localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

  logic [1:0]  state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [7:0]  fillChar_q, fillChar_d;
`ifdef VGA_FILL_COLOR_EN
  logic [7:0]  fillColor_q, fillColor_d;
`endif

  logic ctrlWrite;
  assign ctrlWrite = CpuAccess && CpuWrite && (CpuAddress == CTRL_ADDR);

  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == FINISH);
  assign StatusData = (CpuAddress == STAT_ADDR) ? {19'b0, count_q, Busy} : 32'h0;

  // The fill only advances in cycles the CPU leaves the port free; CTRL writes while busy are ignored.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fillChar_d = fillChar_q;
`ifdef VGA_FILL_COLOR_EN
    fillColor_d = fillColor_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctrlWrite) begin
          state_d    = FILL_CHAR;
          count_d    = 12'd0;
          fillChar_d = CpuWriteData[7:0];
`ifdef VGA_FILL_COLOR_EN
          fillColor_d = CpuWriteData[15:8];
`endif
        end
      end
      FILL_CHAR: begin
        if (!CpuAccess) begin
          if (count_q == LAST_CELL) begin
            count_d = 12'd0;
`ifdef VGA_FILL_COLOR_EN
            state_d = FILL_COLOR;
`else
            state_d = FINISH;
`endif
          end else begin
            count_d = count_q + 12'd1;
          end
        end
      end
`ifdef VGA_FILL_COLOR_EN
      FILL_COLOR: begin
        if (!CpuAccess) begin
          if (count_q == LAST_CELL) begin
            count_d = 12'd0;
            state_d = FINISH;
          end else begin
            count_d = count_q + 12'd1;
          end
        end
      end
`endif
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      count_q    <= 12'd0;
      fillChar_q <= 8'd0;
`ifdef VGA_FILL_COLOR_EN
      fillColor_q <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fillChar_q <= fillChar_d;
`ifdef VGA_FILL_COLOR_EN
      fillColor_q <= fillColor_d;
`endif
    end
  end

  // The CPU always owns the port when it needs it; an idle port drives address 0, which decodes to nothing.
  always_comb begin
    Address   = 32'h0;
    WriteData = 32'h0;
    if (CpuAccess) begin
      Address   = CpuAddress;
      WriteData = CpuWriteData;
    end else if (state_q == FILL_CHAR) begin
      Address   = CHAR_BASE + {20'b0, count_q};
      WriteData = {24'b0, fillChar_q};
    end
`ifdef VGA_FILL_COLOR_EN
    else if (state_q == FILL_COLOR) begin
      Address   = COLOR_BASE + {20'b0, count_q};
      WriteData = {24'b0, fillColor_q};
    end
`endif
  end

endmodule

// File: tb/tb_mmio_vga_fill_arbiter.sv
// Self-checking bench for mmio_vga_fill_arbiter: a progress-counter reference model plus directed spot checks.
// Expectations follow VGA_FILL_COLOR_EN when it is defined for the build.
module tb_mmio_vga_fill_arbiter;

  localparam int          CELLS      = 3072;
  localparam logic [31:0] CHAR_BASE  = 32'hFFFF_E000;
  localparam logic [31:0] COLOR_BASE = 32'hFFFF_D000;
  localparam logic [31:0] CTRL_ADDR  = 32'hFFFF_FF34;
  localparam logic [31:0] STAT_ADDR  = 32'hFFFF_FF38;
`ifdef VGA_FILL_COLOR_EN
  localparam int TOTAL = 2 * CELLS;
`else
  localparam int TOTAL = CELLS;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        CpuAccess = 1'b0;
  logic [31:0] CpuAddress = 32'h0;
  logic [31:0] CpuWriteData = 32'h0;
  logic        CpuWrite = 1'b0;
  logic [31:0] Address, WriteData, StatusData;
  logic        Busy, Done;

  mmio_vga_fill_arbiter dut (
    .clk(clk), .reset(reset), .CpuAccess(CpuAccess), .CpuAddress(CpuAddress),
    .CpuWriteData(CpuWriteData), .CpuWrite(CpuWrite), .Address(Address),
    .WriteData(WriteData), .StatusData(StatusData), .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastDone = -1;

  // Reference model: a fill is just "mK cells written out of TOTAL", char plane first.
  bit         modelValid = 0;
  bit         mActive = 0;
  int         mK = 0;
  logic [7:0] mChar = 8'h0;
  logic [7:0] mColor = 8'h0;

  logic [31:0] obsAddr, obsData, obsStat;
  logic        obsBusy, obsDone;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Drive one cycle at the negedge, compare against the model mid-cycle, then advance the model at the posedge.
  task automatic applyStimulus(input logic acc, input logic [31:0] addr, input logic [31:0] wd,
                               input logic wr, input logic rst);
    logic [31:0] expAddr, expData, expStat;
    logic        expBusy, expDone;
    int          cnt;
    @(negedge clk);
    CpuAccess    = acc;
    CpuAddress   = addr;
    CpuWriteData = wd;
    CpuWrite     = wr;
    reset        = rst;
    #1;
    obsAddr = Address;
    obsData = WriteData;
    obsStat = StatusData;
    obsBusy = Busy;
    obsDone = Done;
    if (modelValid) begin
      expBusy = mActive;
      expDone = mActive && (mK == TOTAL);
      cnt     = (mActive && mK < TOTAL) ? (mK % CELLS) : 0;
      expAddr = 32'h0;
      expData = 32'h0;
      if (acc) begin
        expAddr = addr;
        expData = wd;
      end else if (mActive && mK < CELLS) begin
        expAddr = CHAR_BASE + 32'(mK);
        expData = {24'b0, mChar};
      end else if (mActive && mK < TOTAL) begin
        expAddr = COLOR_BASE + 32'(mK - CELLS);
        expData = {24'b0, mColor};
      end
      expStat = (addr == STAT_ADDR) ? {19'b0, cnt[11:0], expBusy} : 32'h0;
      checkOutput("Address", obsAddr, expAddr);
      checkOutput("WriteData", obsData, expData);
      checkOutput("StatusData", obsStat, expStat);
      checkOutput("Busy", {31'b0, obsBusy}, {31'b0, expBusy});
      checkOutput("Done", {31'b0, obsDone}, {31'b0, expDone});
    end
    if (obsDone === 1'b1) lastDone = cyc;
    @(posedge clk);
    if (!rst) begin
      modelValid = 1;
      mActive    = 0;
      mK         = 0;
      mChar      = 8'h0;
      mColor     = 8'h0;
    end else if (!mActive) begin
      if (acc && wr && addr == CTRL_ADDR) begin
        mActive = 1;
        mK      = 0;
        mChar   = wd[7:0];
        mColor  = wd[15:8];
      end
    end else if (mK == TOTAL) begin
      mActive = 0;
    end else if (!acc) begin
      mK++;
    end
    cyc++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    int contested;
    int guard;
    logic [31:0] rAddr;
    logic [31:0] rData;

    // Reset held for two cycles, then released with the port idle.
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idleCycle();
    checkOutput("resetBusy", {31'b0, obsBusy}, 32'h0);
    checkOutput("resetDone", {31'b0, obsDone}, 32'h0);
    checkOutput("resetAddress", obsAddr, 32'h0);
    checkOutput("resetWriteData", obsData, 32'h0);

    // Uncontested fill with cycle-exact spot checks.
    n = cyc;
    lastDone = -1;
    applyStimulus(1'b1, CTRL_ADDR, 32'h0000_1F41, 1'b1, 1'b1);
    for (int i = 1; i <= TOTAL + 2; i++) begin
      idleCycle();
      if (i == 1) begin
        checkOutput("firstAddr", obsAddr, 32'hFFFF_E000);
        checkOutput("firstData", obsData, 32'h0000_0041);
        checkOutput("firstBusy", {31'b0, obsBusy}, 32'h1);
      end
      if (i == CELLS) checkOutput("lastCharAddr", obsAddr, 32'hFFFF_EBFF);
      if (i == CELLS + 1) begin
`ifdef VGA_FILL_COLOR_EN
        checkOutput("firstColorAddr", obsAddr, 32'hFFFF_D000);
        checkOutput("firstColorData", obsData, 32'h0000_001F);
`else
        checkOutput("noColorAddr", obsAddr, 32'h0);
        checkOutput("noColorDone", {31'b0, obsDone}, 32'h1);
`endif
      end
      if (i == TOTAL + 2) checkOutput("busyFalls", {31'b0, obsBusy}, 32'h0);
    end
    checkOutput("uncontestedDoneLatency", 32'(lastDone - n), 32'(TOTAL + 1));

    // Randomly contested fill, including a 5-cycle burst and an ignored CTRL write.
    n = cyc;
    lastDone = -1;
    contested = 0;
    rData = $urandom;
    applyStimulus(1'b1, CTRL_ADDR, rData, 1'b1, 1'b1);
    guard = 0;
    while (lastDone < 0 && guard < 20000) begin
      guard++;
      if (guard >= 10 && guard < 15) begin
        applyStimulus(1'b1, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b1);
        checkOutput("burstAddr", obsAddr, 32'hFFFF_FF00);
      end else if (guard == 20) begin
        applyStimulus(1'b1, CTRL_ADDR, 32'h0, 1'b1, 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rAddr = STAT_ADDR;
          1:       rAddr = CTRL_ADDR;
          2:       rAddr = CHAR_BASE + 32'($urandom_range(0, CELLS - 1));
          default: rAddr = 32'hFFFF_FF00;
        endcase
        applyStimulus(1'b1, rAddr, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      end else begin
        idleCycle();
      end
      if (lastDone < 0 && CpuAccess) contested++;
    end
    checkOutput("contestedDoneSeen", {31'b0, lastDone >= 0}, 32'h1);
    checkOutput("contestedDoneLatency", 32'(lastDone - n), 32'(TOTAL + 1 + contested));
    idleCycle();
    idleCycle();

    // Reset mid-fill at Count == 100 abandons the fill without a Done pulse.
    applyStimulus(1'b1, CTRL_ADDR, 32'h0000_1F41, 1'b1, 1'b1);
    guard = 0;
    while (mK < 100 && guard < 500) begin
      guard++;
      idleCycle();
    end
    applyStimulus(1'b1, STAT_ADDR, 32'h0, 1'b0, 1'b1);
    checkOutput("statusAt100", obsStat, 32'h0000_00C9);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    lastDone = -1;
    idleCycle();
    checkOutput("busyAfterReset", {31'b0, obsBusy}, 32'h0);
    checkOutput("addrAfterReset", obsAddr, 32'h0);
    for (int i = 0; i < 5; i++) idleCycle();
    checkOutput("noDoneAfterReset", {31'b0, lastDone == -1}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
